// File: rtl/bomb_control_unit_pkg.sv
// Shared definitions for the bomb controller: timer-register control codes,
// FSM state encodings and the state-to-flag decode.
package bomb_control_unit_pkg;

  // Control codes understood by the downstream countdown timer register.
  localparam logic [2:0] CTRL_NONE = 3'd0;
  localparam logic [2:0] CTRL_CLR  = 3'd1;
  localparam logic [2:0] CTRL_LOAD = 3'd2;
  localparam logic [2:0] CTRL_INCR = 3'd3;
  localparam logic [2:0] CTRL_DECR = 3'd4;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_DISARMED = 2'd2;
  localparam logic [1:0] ST_EXPLODED = 2'd3;

  typedef struct packed {
    logic armed;
    logic disarmed;
    logic exploded;
  } flags_t;

  function automatic flags_t decode_flags(input logic [1:0] st);
    flags_t f;
    f.armed    = (st == ST_ARMED);
    f.disarmed = (st == ST_DISARMED);
    f.exploded = (st == ST_EXPLODED);
    return f;
  endfunction

endpackage

// File: rtl/bomb_control_unit_if.sv
// Bus between the bomb controller, its operator inputs and the timer register.
// master = environment side, slave = bomb_control_unit.
interface bomb_control_unit_if #(
  parameter int TIMER_WIDTH = 8,
  parameter int CTRL_WIDTH  = 3,
  parameter int CODE_WIDTH  = 4
);
  logic                   arm;
  logic [CODE_WIDTH-1:0]  code_in;
  logic                   code_valid;
  logic                   clear;
  logic [TIMER_WIDTH-1:0] timer_value;
  logic [CTRL_WIDTH-1:0]  timer_ctrl;
  logic [TIMER_WIDTH-1:0] timer_load;
  logic                   armed;
  logic                   disarmed;
  logic                   exploded;
  logic [3:0]             tries_left;

  modport master (
    output arm, code_in, code_valid, clear, timer_value,
    input  timer_ctrl, timer_load, armed, disarmed, exploded, tries_left
  );

  modport slave (
    input  arm, code_in, code_valid, clear, timer_value,
    output timer_ctrl, timer_load, armed, disarmed, exploded, tries_left
  );
endinterface

// File: rtl/bomb_control_unit_tick_prescaler.sv
// Free-running divider that emits a one-cycle tick every TICK_DIV cycles
// while enabled; held at zero whenever disabled.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int              CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = (count == LAST) ? '0 : count + 1'b1;
  end

  // Tick is registered from the next count so it is high exactly while the
  // count sits at LAST, putting the first tick TICK_DIV cycles after enable.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (!enable) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= count_next;
      tick  <= (count_next == LAST);
    end
  end

endmodule

// File: rtl/bomb_control_unit.sv
// Bomb controller FSM: arms and decrements the external countdown register,
// checks entered codes, counts wrong attempts and resolves the game.
module bomb_control_unit
  import bomb_control_unit_pkg::*;
#(
  parameter int                    TIMER_WIDTH = 8,
  parameter int                    CTRL_WIDTH  = 3,
  parameter int                    TICK_DIV    = 50000000,
  parameter int                    INIT_TIME   = 30,
  parameter int                    CODE_WIDTH  = 4,
  parameter logic [CODE_WIDTH-1:0] SECRET      = 4'h5,
  parameter int                    MAX_TRIES   = 3
) (
  input logic               clk,
  input logic               rst,
  bomb_control_unit_if.slave bus
);

  localparam logic [3:0] TRIES_INIT = 4'(MAX_TRIES);

  logic [1:0] state;
  logic [1:0] state_next;
  logic [3:0] tries;
  logic [3:0] tries_next;
  logic [2:0] ctrl_code;
  logic       tick;
  logic       code_hit;
  logic       code_miss;
  flags_t     flags;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (state == ST_ARMED),
    .tick   (tick)
  );

  assign code_hit  = bus.code_valid && (bus.code_in == SECRET);
  assign code_miss = bus.code_valid && (bus.code_in != SECRET);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_next = state;
    tries_next = tries;
    ctrl_code  = CTRL_NONE;

    case (state)
      ST_IDLE: begin
        if (bus.arm) begin
          ctrl_code  = CTRL_LOAD;
          state_next = ST_ARMED;
          tries_next = TRIES_INIT;
        end
      end

      ST_ARMED: begin
        // A correct code wins outright; any tick in the same cycle is dropped.
        if (code_hit) begin
          state_next = ST_DISARMED;
        end else begin
          if (code_miss && (tries != 4'd0)) begin
            tries_next = tries - 4'd1;
          end
          if (code_miss && (tries <= 4'd1)) begin
            state_next = ST_EXPLODED;
          end else if (tick) begin
            if (bus.timer_value == '0) begin
              state_next = ST_EXPLODED;
            end else begin
              ctrl_code = CTRL_DECR;
            end
          end
        end
      end

      ST_DISARMED, ST_EXPLODED: begin
        if (bus.clear) begin
          ctrl_code  = CTRL_CLR;
          state_next = ST_IDLE;
          tries_next = TRIES_INIT;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      tries <= TRIES_INIT;
    end else begin
      state <= state_next;
      tries <= tries_next;
    end
  end

  assign flags          = decode_flags(state);
  assign bus.armed      = flags.armed;
  assign bus.disarmed   = flags.disarmed;
  assign bus.exploded   = flags.exploded;
  assign bus.tries_left = tries;
  assign bus.timer_ctrl = CTRL_WIDTH'(ctrl_code);
  assign bus.timer_load = TIMER_WIDTH'(INIT_TIME);

endmodule
